// File: rtl/pipe_stage_buffer.sv
// Inter-stage pipeline register with valid/ready handshake, stall and flush.
// Define PIPE_STAGE_BUFFER_SKID_EN for the 2-entry build with a fully registered o_ready.
module pipe_stage_buffer #(
    parameter int CTRL_WIDTH = 32,
    parameter int DATA_WIDTH = 80
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_flush,
    input  logic                  i_stall,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [CTRL_WIDTH-1:0] i_ctrl,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [CTRL_WIDTH-1:0] o_ctrl,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_count
);

    logic                  r_main_valid;
    logic [CTRL_WIDTH-1:0] r_main_ctrl;
    logic [DATA_WIDTH-1:0] r_main_data;

    logic w_accept;
    logic w_release;

    assign w_accept  = i_valid & o_ready & ~i_stall;
    assign w_release = r_main_valid & i_ready & ~i_stall;

    // Gate the head so an empty buffer always presents a NOP downstream.
    assign o_valid = r_main_valid;
    assign o_ctrl  = r_main_valid ? r_main_ctrl : '0;
    assign o_data  = r_main_valid ? r_main_data : '0;

`ifdef PIPE_STAGE_BUFFER_SKID_EN
    logic                  r_skid_valid;
    logic [CTRL_WIDTH-1:0] r_skid_ctrl;
    logic [DATA_WIDTH-1:0] r_skid_data;

    // Ready comes straight from a flop, so no path from i_ready reaches upstream.
    assign o_ready = ~r_skid_valid;
    assign o_count = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_data  <= '0;
        end else if (!i_stall) begin
            if (r_skid_valid) begin
                if (w_release) begin
                    r_main_ctrl  <= r_skid_ctrl;
                    r_main_data  <= r_skid_data;
                    r_skid_valid <= 1'b0;
                    r_skid_ctrl  <= '0;
                    r_skid_data  <= '0;
                end
            end else if (r_main_valid) begin
                if (w_release) begin
                    if (w_accept) begin
                        r_main_ctrl <= i_ctrl;
                        r_main_data <= i_data;
                    end else begin
                        r_main_valid <= 1'b0;
                    end
                end else if (w_accept) begin
                    r_skid_valid <= 1'b1;
                    r_skid_ctrl  <= i_ctrl;
                    r_skid_data  <= i_data;
                end
            end else if (w_accept) begin
                r_main_valid <= 1'b1;
                r_main_ctrl  <= i_ctrl;
                r_main_data  <= i_data;
            end
        end
    end
`else
    // Single entry: a full buffer can only take a new entry while releasing its head.
    assign o_ready = ~i_stall & (~r_main_valid | i_ready);
    assign o_count = {1'b0, r_main_valid};

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_main_data  <= '0;
        end else if (w_accept) begin
            r_main_valid <= 1'b1;
            r_main_ctrl  <= i_ctrl;
            r_main_data  <= i_data;
        end else if (w_release) begin
            r_main_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed self-checking bench for pipe_stage_buffer (either build).
module tb_pipe_stage_buffer;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_flush = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_ctrl = '0;
    logic [79:0] i_data = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_ctrl;
    logic [79:0] o_data;
    logic [1:0]  o_count;

    int total = 0;
    int bad   = 0;

    pipe_stage_buffer #(.CTRL_WIDTH(32), .DATA_WIDTH(80)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_stall(i_stall),
        .i_valid(i_valid), .o_ready(o_ready), .i_ctrl(i_ctrl), .i_data(i_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_ctrl(o_ctrl), .o_data(o_data),
        .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [79:0] data_of(input logic [31:0] c);
        return {48'hC0DE_0000_BEEF, c};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] c, input logic rdy);
        i_valid = v;
        i_ctrl  = c;
        i_data  = data_of(c);
        i_ready = rdy;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        drive(1'b1, 32'hFFFF_FFFF, 1'b1);
        tick();
        tick();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", o_valid); end
        total++; if (o_ctrl !== 32'h0) begin bad++; $display("FAIL reset_ctrl got=%0h want=0", o_ctrl); end
        total++; if (o_data !== 80'h0) begin bad++; $display("FAIL reset_data got=%0h want=0", o_data); end
        total++; if (o_count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", o_count); end
        i_reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        tick();
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", o_ready); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_valid got=%0b want=0", o_valid); end
        $display("reset: valid=%0b ctrl=%0h count=%0d ready=%0b", o_valid, o_ctrl, o_count, o_ready);
    endtask

    task automatic test_streaming();
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 32'(k), 1'b1);
            #1;
            total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%0b want=1", k, o_ready); end
            tick();
            total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%0b want=1", k, o_valid); end
            total++; if (o_ctrl !== 32'(k)) begin bad++; $display("FAIL stream_ctrl[%0d] got=%0h want=%0h", k, o_ctrl, k); end
            total++; if (o_data !== data_of(32'(k))) begin bad++; $display("FAIL stream_data[%0d] got=%0h want=%0h", k, o_data, data_of(32'(k))); end
            total++; if (o_count !== 2'd1) begin bad++; $display("FAIL stream_count[%0d] got=%0d want=1", k, o_count); end
            $display("stream: ctrl=%0h count=%0d", o_ctrl, o_count);
        end
        drive(1'b0, 32'h0, 1'b1);
        tick();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL stream_drain_valid got=%0b want=0", o_valid); end
        total++; if (o_count !== 2'd0) begin bad++; $display("FAIL stream_drain_count got=%0d want=0", o_count); end
    endtask

    task automatic test_backpressure();
        logic [1:0] exp_full_count;
        logic       exp_full_ready;
        logic [31:0] exp_after1;
`ifdef PIPE_STAGE_BUFFER_SKID_EN
        exp_full_count = 2'd2;
        exp_full_ready = 1'b0;
        exp_after1     = 32'd6;
`else
        exp_full_count = 2'd1;
        exp_full_ready = 1'b0;
        exp_after1     = 32'd6;
`endif
        drive(1'b1, 32'd5, 1'b0);
        tick();
        total++; if (o_ctrl !== 32'd5) begin bad++; $display("FAIL bp_first got=%0h want=5", o_ctrl); end
`ifdef PIPE_STAGE_BUFFER_SKID_EN
        drive(1'b1, 32'd6, 1'b0);
        tick();
`endif
        drive(1'b1, 32'd7, 1'b0);
        tick();
        tick();
        total++; if (o_ctrl !== 32'd5) begin bad++; $display("FAIL bp_hold_ctrl got=%0h want=5", o_ctrl); end
        total++; if (o_count !== exp_full_count) begin bad++; $display("FAIL bp_count got=%0d want=%0d", o_count, exp_full_count); end
        total++; if (o_ready !== exp_full_ready) begin bad++; $display("FAIL bp_ready got=%0b want=%0b", o_ready, exp_full_ready); end
        $display("backpressure: ctrl=%0h count=%0d ready=%0b", o_ctrl, o_count, o_ready);
`ifdef PIPE_STAGE_BUFFER_SKID_EN
        drive(1'b1, 32'd7, 1'b1);
`else
        drive(1'b1, 32'd6, 1'b1);
`endif
        tick();
        total++; if (o_ctrl !== exp_after1) begin bad++; $display("FAIL bp_out2 got=%0h want=%0h", o_ctrl, exp_after1); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL bp_recover_ready got=%0b want=1", o_ready); end
        drive(1'b1, 32'd7, 1'b1);
        tick();
        total++; if (o_ctrl !== 32'd7) begin bad++; $display("FAIL bp_out3 got=%0h want=7", o_ctrl); end
        total++; if (o_count !== 2'd1) begin bad++; $display("FAIL bp_out3_count got=%0d want=1", o_count); end
        drive(1'b0, 32'h0, 1'b1);
        tick();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b want=0", o_valid); end
        $display("backpressure drained: valid=%0b count=%0d", o_valid, o_count);
    endtask

    task automatic test_flush();
        drive(1'b1, 32'd10, 1'b0);
        tick();
        drive(1'b1, 32'd11, 1'b0);
        tick();
        i_flush = 1'b1;
        drive(1'b1, 32'd9, 1'b0);
        tick();
        i_flush = 1'b0;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b want=0", o_valid); end
        total++; if (o_ctrl !== 32'h0) begin bad++; $display("FAIL flush_ctrl got=%0h want=0", o_ctrl); end
        total++; if (o_count !== 2'd0) begin bad++; $display("FAIL flush_count got=%0d want=0", o_count); end
        drive(1'b0, 32'h0, 1'b1);
        tick();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped got=%0b want=0 ctrl=%0h", o_valid, o_ctrl); end
        $display("flush: valid=%0b ctrl=%0h count=%0d", o_valid, o_ctrl, o_count);
    endtask

    task automatic test_stall();
        logic exp_stall_ready;
`ifdef PIPE_STAGE_BUFFER_SKID_EN
        exp_stall_ready = 1'b1;
`else
        exp_stall_ready = 1'b0;
`endif
        drive(1'b1, 32'd3, 1'b1);
        tick();
        i_stall = 1'b1;
        drive(1'b1, 32'd4, 1'b1);
        #1;
        total++; if (o_ready !== exp_stall_ready) begin bad++; $display("FAIL stall_ready got=%0b want=%0b", o_ready, exp_stall_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (o_ctrl !== 32'd3) begin bad++; $display("FAIL stall_ctrl[%0d] got=%0h want=3", k, o_ctrl); end
            total++; if (o_count !== 2'd1) begin bad++; $display("FAIL stall_count[%0d] got=%0d want=1", k, o_count); end
            $display("stall: ctrl=%0h count=%0d", o_ctrl, o_count);
        end
        i_stall = 1'b0;
        tick();
        total++; if (o_ctrl !== 32'd4) begin bad++; $display("FAIL stall_resume got=%0h want=4", o_ctrl); end
        drive(1'b0, 32'h0, 1'b1);
        tick();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%0b want=0", o_valid); end
    endtask

    task automatic test_flush_stall();
        drive(1'b1, 32'd12, 1'b0);
        tick();
        total++; if (o_ctrl !== 32'd12) begin bad++; $display("FAIL fs_load got=%0h want=c", o_ctrl); end
        i_flush = 1'b1;
        i_stall = 1'b1;
        drive(1'b1, 32'd13, 1'b0);
        tick();
        i_flush = 1'b0;
        i_stall = 1'b0;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL fs_valid got=%0b want=0", o_valid); end
        total++; if (o_count !== 2'd0) begin bad++; $display("FAIL fs_count got=%0d want=0", o_count); end
        drive(1'b0, 32'h0, 1'b1);
        tick();
        $display("flush+stall: valid=%0b count=%0d", o_valid, o_count);
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 32'd20, 1'b0);
        tick();
        total++; if (o_ctrl !== 32'd20) begin bad++; $display("FAIL rm_load got=%0h want=14", o_ctrl); end
        i_reset = 1'b1;
        drive(1'b1, 32'd21, 1'b1);
        tick();
        i_reset = 1'b0;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%0b want=0", o_valid); end
        total++; if (o_data !== 80'h0) begin bad++; $display("FAIL rm_data got=%0h want=0", o_data); end
        drive(1'b0, 32'h0, 1'b1);
        tick();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rm_no_accept got=%0b want=0 ctrl=%0h", o_valid, o_ctrl); end
        $display("reset midstream: valid=%0b count=%0d", o_valid, o_count);
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_stall();
        test_flush_stall();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buffer.md
# pipe_stage_buffer

Parametrised inter-stage pipeline register that replaces the fixed-field decode/execute-style buffers. It carries an opaque control bundle and data bundle between two pipeline stages using a valid/ready handshake, with stall and flush (bubble insertion) support. It also optionally provides a 2-entry skid so upstream ready is fully registered. One instance sits between each pair of adjacent pipeline stages (fetch/decode, decode/execute, execute/writeback).

## Interface

Parameters:
- CTRL_WIDTH, 32: width of control bundle; zeroed on flush/reset (zero = NOP).
- DATA_WIDTH, 80: width of data bundle (operands, register ids, PC).

Ports:
- i_clk  in  1  clock, rising-edge.
- i_reset  in  1  reset i_reset, synchronous, active-high; clock i_clk.
- i_flush  in  1  discard all held entries at next edge.
- i_stall  in  1  freeze: no accept, no release, contents held.
- i_valid  in  1  upstream entry valid.
- o_ready  out  1  buffer can accept this cycle.
- i_ctrl  in  CTRL_WIDTH  upstream control bundle.
- i_data  in  DATA_WIDTH  upstream data bundle.
- o_valid  out  1  head entry valid.
- i_ready  in  1  downstream accepts head this cycle.
- o_ctrl  out  CTRL_WIDTH  head control; 0 whenever o_valid=0.
- o_data  out  DATA_WIDTH  head data; 0 whenever o_valid=0.
- o_count  out  2  occupancy, 0..2 (0..1 without skid).

## Operation

- Accept = i_valid & o_ready & ~i_stall; release = o_valid & i_ready & ~i_stall.
- Priority per edge: i_reset > i_flush > i_stall > normal transfer.
- Reset/flush: both entries invalid, ctrl and data registers zeroed, o_count=0. An input presented in the flush cycle is dropped.
- Stall: all state held. Without skid o_ready=0 during stall; with skid o_ready keeps its registered value but no accept happens.
- Entries: main (drives outputs) and skid (skid build only).
- Transitions (skid build), with no stall/flush:
  - Empty + accept: main <= input.
  - Main only, release, no accept: empty.
  - Main only, release + accept: main <= input.
  - Main only, accept, no release: skid <= input (count 2).
  - Main+skid, release: main <= skid, skid empty.
  - Main+skid, no release: hold.
- o_ready (skid build) = ~skid_valid, registered (no combinational path from i_ready).
- Ordering strictly FIFO; no entry duplicated or lost except by flush/reset.

## Timing

- Latency: accepted entry appears on o_* the cycle after acceptance (1 cycle) when main was empty or releasing.
- Throughput: 1 entry/cycle sustained when i_ready=1.
- Reset values: o_valid=0, o_ctrl=0, o_data=0, o_count=0; o_ready=1 after reset (skid build), =~i_stall otherwise.
- Downstream deassert of i_ready for N cycles with continuous input: skid build absorbs 1 extra entry, o_ready=0 from the cycle after skid fills, recovers the cycle after the first release.
- Reset asserted mid-transfer: takes effect at that edge; nothing accepted or released that cycle.

## Configuration

- PIPE_STAGE_BUFFER_SKID_EN defined: 2-entry build as above, o_ready registered, o_count 0..2.
- Undefined: single main entry only; o_ready = ~i_stall & (~o_valid | i_ready) combinational; accept with main full only when simultaneously releasing; o_count 0..1. Reset/flush/stall semantics identical.

## Test plan

- Reset: hold i_reset 2 cycles with i_valid=1, i_ctrl=0xFFFFFFFF -> o_valid=0, o_ctrl=0, o_data=0, o_count=0; o_ready=1 the cycle after release.
- Streaming: i_ready=1, feed ctrl 1,2,3,4 back-to-back -> o_ctrl 1,2,3,4 on consecutive cycles, each 1 cycle after acceptance, o_count stays 1.
- Backpressure (skid): feed 5,6,7 continuously, i_ready=0 from cycle 1 -> o_ctrl holds 5, 6 held in skid, o_count=2, o_ready=0, 7 held upstream. With i_ready=1 -> 5,6,7 emerge in order with no loss.
- Flush: buffer holds 2 entries, assert i_flush with i_valid=1 (ctrl 9) -> next cycle o_valid=0, o_ctrl=0, o_count=0; 9 never appears.
- Stall: o_ctrl=0x3, i_ready=1, i_valid=1, i_stall=1 for 3 cycles -> o_ctrl stays 0x3, o_count unchanged, no accept; release resumes.
- Flush+stall same cycle: flush wins -> empty next cycle.
